// File: rtl/ex_alu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_stage
// Brief    : Execute-stage ALU with registered valid/ready result slot.
//            Define ALU_ITER_SHIFT_EN to build the iterative 1-bit/cycle shifter.
// Revision : 1.0 - initial release
// ============================================================================
module ex_alu_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic             slot_free;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_result;
  logic             load_illegal;
  logic [WIDTH-1:0] comb_result;
  logic             comb_illegal;

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Shift codes fall into default: illegal in the non-iterative build, never loaded from here otherwise.
  always_comb begin
    comb_result  = '0;
    comb_illegal = 1'b0;
    case (alu_control)
      OP_ADD:  comb_result = src_a + src_b;
      OP_SUB:  comb_result = src_a - src_b;
      OP_AND:  comb_result = src_a & src_b;
      OP_OR:   comb_result = src_a | src_b;
      OP_SLT:  comb_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: comb_illegal = 1'b1;
    endcase
  end

`ifdef ALU_ITER_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             is_shift;
  logic [WIDTH-1:0] shift_val;
  logic [SHW-1:0]   shift_cnt;
  logic             shift_left;
  logic             shift_arith;

  assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                    (alu_control == OP_SRA);
  assign in_ready = rst_n && (state == IDLE) && !flush && slot_free;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    load         = 1'b0;
    load_result  = comb_result;
    load_illegal = comb_illegal;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift) state_next = SHIFT;
            else          load       = 1'b1;
          end
        end
        SHIFT: begin
          if ((shift_cnt == '0) && slot_free) begin
            load         = 1'b1;
            load_result  = shift_val;
            load_illegal = 1'b0;
            state_next   = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_val   <= '0;
      shift_cnt   <= '0;
      shift_left  <= 1'b0;
      shift_arith <= 1'b0;
    end else if (accept && is_shift) begin
      shift_val   <= src_a;
      shift_cnt   <= src_b[SHW-1:0];
      shift_left  <= (alu_control == OP_SLL);
      shift_arith <= (alu_control == OP_SRA);
    end else if ((state == SHIFT) && (shift_cnt != '0)) begin
      shift_cnt <= shift_cnt - 1'b1;
      if (shift_left) shift_val <= {shift_val[WIDTH-2:0], 1'b0};
      else            shift_val <= {shift_arith & shift_val[WIDTH-1], shift_val[WIDTH-1:1]};
    end
  end
`else
  assign in_ready     = rst_n && !flush && slot_free;
  assign load         = accept;
  assign load_result  = comb_result;
  assign load_illegal = comb_illegal;
`endif

  // Flush only drops out_valid; the stale data is never presented as valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero       <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      alu_result <= load_result;
      zero       <= (load_result == '0);
      illegal    <= load_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_alu_stage
// Brief    : Randomized + directed self-checking bench for ex_alu_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_alu_stage;

  localparam int WIDTH = 32;
  localparam int SHW   = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             illegal;

  ex_alu_stage #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_result  (alu_result),
    .zero        (zero),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ill;
    int               rdy;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic in_rst   = 1'b0;
  logic acc_flag = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference semantics straight from the operation table.
  function automatic void ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] r,
                                 output logic ill, output int lat);
    int sh;
    sh  = int'(b[SHW-1:0]);
    r   = '0;
    ill = 1'b0;
    lat = 1;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: begin
`ifdef ALU_ITER_SHIFT_EN
        lat = 2 + sh;
        if (op == 3'd4)      r = a << sh;
        else if (op == 3'd6) r = a >> sh;
        else                 r = $signed(a) >>> sh;
`else
        ill = 1'b1;
`endif
      end
    endcase
  endfunction

  task automatic observe();
    logic             exp_valid;
    logic             busy;
    logic             exp_ready;
    logic [WIDTH-1:0] r;
    logic             il;
    int               lat;
    exp_t             e;
    acc_flag = 1'b0;
    if (in_rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_result", alu_result, 0);
      check("rst_zero", zero, 0);
      check("rst_illegal", illegal, 0);
    end
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 0);
      return;
    end
    exp_valid = (q.size() > 0) && (cyc >= q[0].rdy);
    busy      = (q.size() > 0) && (cyc < q[0].rdy);
    exp_ready = !flush && !busy && (!exp_valid || out_ready);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      check("result", alu_result, q[0].res);
      check("zero", zero, (q[0].res == '0));
      check("illegal", illegal, q[0].ill);
    end
    if (flush) begin
      q.delete();
    end else begin
      if (exp_valid && out_ready) void'(q.pop_front());
      if (exp_ready && in_valid) begin
        ref_op(alu_control, src_a, src_b, r, il, lat);
        e.res = r; e.ill = il; e.rdy = cyc + lat;
        q.push_back(e);
        acc_flag = 1'b1;
      end
    end
  endtask

  task automatic tick();
    logic pre_rst;
    @(negedge clk);
    observe();
    pre_rst = rst_n;
    @(posedge clk);
    cyc++;
    in_rst = !pre_rst;
    if (!pre_rst) q.delete();
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, output int waited);
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    waited      = 0;
    do begin
      tick();
      waited++;
    end while (!acc_flag && waited < 100);
    if (!acc_flag) check("issue_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    if (q.size() > 0) check("drain_timeout", 1, 0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; alu_control = 3'd0;
    src_a = '0; src_b = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    issue(3'd0, 32'd5, 32'd7, w);
    issue(3'd1, 32'd9, 32'd9, w);
    issue(3'd0, 32'hFFFF_FFFF, 32'd1, w);
    issue(3'd2, 32'h0000_F0F0, 32'h0000_FF00, w);
    issue(3'd3, 32'h0000_F0F0, 32'h0000_FF00, w);
    issue(3'd5, 32'hFFFF_FFFF, 32'd1, w);
    issue(3'd5, 32'd1, 32'hFFFF_FFFF, w);
    drain();

    // Backpressure: result held for 3 cycles, next op taken when out_ready rises.
    out_ready = 1'b0;
    issue(3'd0, 32'd100, 32'd23, w);
    repeat (3) tick();
    out_ready = 1'b1;
    issue(3'd1, 32'd50, 32'd8, w);
    check("bp_accept_wait", w, 1);
    drain();

`ifdef ALU_ITER_SHIFT_EN
    issue(3'd4, 32'd1, 32'd4, w);
    drain();
    issue(3'd7, 32'h8000_0000, 32'd31, w);
    drain();
    issue(3'd6, 32'h1234_5678, 32'd0, w);
    drain();
    issue(3'd4, 32'hA5A5_A5A5, 32'd20, w);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue(3'd0, 32'd3, 32'd4, w);
    check("post_flush_wait", w, 1);
    drain();
`else
    issue(3'd6, 32'h1234_5678, 32'd3, w);
    issue(3'd4, 32'd1, 32'd4, w);
    issue(3'd7, 32'h8000_0000, 32'd31, w);
    drain();
    out_ready = 1'b0;
    issue(3'd0, 32'd1, 32'd1, w);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b1;
    issue(3'd0, 32'd3, 32'd4, w);
    check("post_flush_wait", w, 1);
    drain();
`endif

    for (int i = 0; i < 600; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      alu_control = 3'($urandom_range(0, 7));
      src_a       = $urandom;
      case ($urandom_range(0, 3))
        0:       src_b = src_a;
        1:       src_b = 32'($urandom_range(0, 40));
        default: src_b = $urandom;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    issue(3'd0, 32'd1, 32'd2, w);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
